// File: rtl/btn_event_ctrl_if.sv
// Event port from the button event controller to its consumer (valid/ready).
interface btn_event_ctrl_if #(
    parameter int ID_W = 2
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic [1:0]      ev_type;

    modport master (output ev_valid, ev_id, ev_type, input ev_ready);
    modport slave  (input ev_valid, ev_id, ev_type, output ev_ready);
endinterface

// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into PRESS / REPEAT / RELEASE events, one
// pending slot per button, round-robin onto a single valid/ready port.
module btn_event_ctrl #(
    parameter int N_BTN     = 4,
    parameter int FPGA_CLK  = 50000000,
    parameter int TICK_DIV  = FPGA_CLK / 1000,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int ID_W      = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_db_i,
    input  logic             repeat_en_i,
    input  logic             clr_ovf_i,
    output logic             ovf_o,
    btn_event_ctrl_if.master ev
);
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_RPT} st_e;

    localparam logic [1:0] EV_NONE  = 2'b00;
    localparam logic [1:0] EV_PRESS = 2'b01;
    localparam logic [1:0] EV_RPT   = 2'b10;
    localparam logic [1:0] EV_REL   = 2'b11;

    localparam int CNT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MS - 1);
    localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(REPEAT_MS - 1);
    localparam logic [PRE_W-1:0] PRE_LIM  = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic                  ms_tick;
    logic [N_BTN-1:0]      btn_q, rise, fall;
    logic [N_BTN-1:0]      pend_q, pend_d, ovf_set, gnt_vec;
    logic [N_BTN-1:0][1:0] ptype_q, ptype_d;
    logic [ID_W-1:0]       ptr_q, ptr_d, gnt_id, id_q, id_d;
    logic [1:0]            type_q, type_d;
    logic                  vld_q, vld_d, ovf_q, ovf_d, load;

    assign ms_tick = (pre_q == PRE_LIM);
    assign pre_d   = ms_tick ? '0 : pre_q + 1'b1;
    assign rise    = btn_db_i & ~btn_q;
    assign fall    = ~btn_db_i & btn_q;

    // Round-robin: first pending slot at or after ptr_q, wrapping.
    always_comb begin
        int              idx_i;
        logic [ID_W-1:0] cand;
        logic            found;
        idx_i  = 0;
        cand   = '0;
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= N_BTN) idx_i = idx_i - N_BTN;
            cand = ID_W'(idx_i);
            if (!found && pend_q[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    assign load    = (~vld_q | ev.ev_ready) & (|pend_q);
    assign gnt_vec = load ? (N_BTN'(1) << gnt_id) : '0;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        st_e              st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [1:0]       emit, ptype_nx;
        logic             pend_nx, ovf_nx;

        always_ff @(posedge clk) begin
            if (!rst) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            emit  = EV_NONE;
            case (st_q)
                ST_IDLE: if (rise[i]) begin
                    st_d  = ST_HELD;
                    cnt_d = '0;
                    emit  = EV_PRESS;
                end
                ST_HELD: if (fall[i]) begin
                    st_d = ST_IDLE;
                    emit = EV_REL;
                end else if (ms_tick && repeat_en_i) begin
                    if (cnt_q == HOLD_LIM) begin
                        st_d  = ST_RPT;
                        cnt_d = '0;
                        emit  = EV_RPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RPT: if (fall[i]) begin
                    st_d = ST_IDLE;
                    emit = EV_REL;
                end else if (ms_tick && repeat_en_i) begin
                    if (cnt_q == RPT_LIM) begin
                        cnt_d = '0;
                        emit  = EV_RPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        // Repeats are lossy; a RELEASE may replace a queued REPEAT.
        always_comb begin
            pend_nx  = pend_q[i] & ~gnt_vec[i];
            ptype_nx = ptype_q[i];
            ovf_nx   = 1'b0;
            if (emit != EV_NONE) begin
                if (!pend_q[i] || gnt_vec[i]) begin
                    pend_nx  = 1'b1;
                    ptype_nx = emit;
                end else if (emit == EV_REL && ptype_q[i] == EV_RPT) begin
                    ptype_nx = EV_REL;
                end else if (emit != EV_RPT) begin
                    ovf_nx = 1'b1;
                end
            end
        end

        assign pend_d[i]  = pend_nx;
        assign ptype_d[i] = ptype_nx;
        assign ovf_set[i] = ovf_nx;
    end

    always_comb begin
        vld_d  = vld_q;
        id_d   = id_q;
        type_d = type_q;
        ptr_d  = ptr_q;
        if (load) begin
            vld_d  = 1'b1;
            id_d   = gnt_id;
            type_d = ptype_q[gnt_id];
            ptr_d  = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
        end else if (ev.ev_ready) begin
            vld_d = 1'b0;
        end
    end

    assign ovf_d = (ovf_q & ~clr_ovf_i) | (|ovf_set);

    // History tracks the live level through reset so a button held across
    // reset does not produce a spurious PRESS (or a later orphan RELEASE).
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q   <= '0;
            btn_q   <= btn_db_i;
            pend_q  <= '0;
            ptype_q <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            type_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            btn_q   <= btn_db_i;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ev.ev_valid = vld_q;
    assign ev.ev_id    = id_q;
    assign ev.ev_type  = type_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against an
// event-level reference model (tick ages, one-deep slots, round-robin).
module tb_btn_event_ctrl;
    localparam int N = 4, TD = 10, HOLD = 5, REP = 2, IDW = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_db = '0;
    logic         repeat_en = 1'b1, clr_ovf = 1'b0, ovf;
    int           checks = 0, errors = 0;
    int           n_press = 0, n_rpt = 0, n_rel = 0;

    btn_event_ctrl_if #(.ID_W(IDW)) evif ();

    btn_event_ctrl #(.N_BTN(N), .TICK_DIV(TD), .HOLD_MS(HOLD), .REPEAT_MS(REP)) dut (
        .clk(clk), .rst(rst), .btn_db_i(btn_db), .repeat_en_i(repeat_en),
        .clr_ovf_i(clr_ovf), .ovf_o(ovf), .ev(evif.master)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_cyc, m_ptr, m_id, mt_gid;
    bit         m_valid, m_ovf, mt_tick;
    logic [1:0] m_type, mt_e;
    bit         m_prev[N], m_held[N], m_pend[N];
    int         m_age[N];
    logic [1:0] m_ptype[N];

    always @(posedge clk) begin
        if (!rst) begin
            m_cyc = 0; m_ptr = 0; m_valid = 0; m_id = 0; m_type = 0; m_ovf = 0;
            for (int b = 0; b < N; b++) begin
                m_prev[b] = btn_db[b]; m_held[b] = 0; m_age[b] = 0;
                m_pend[b] = 0; m_ptype[b] = 0;
            end
        end else begin
            mt_tick = (m_cyc % TD) == TD - 1;
            m_cyc++;
            mt_gid = -1;
            if (!m_valid || evif.ev_ready)
                for (int k = 0; k < N; k++)
                    if (mt_gid < 0 && m_pend[(m_ptr + k) % N]) mt_gid = (m_ptr + k) % N;
            if (mt_gid >= 0) begin
                m_valid = 1; m_id = mt_gid; m_type = m_ptype[mt_gid];
                m_ptr = (mt_gid + 1) % N; m_pend[mt_gid] = 0;
            end else if (evif.ev_ready) begin
                m_valid = 0;
            end
            if (clr_ovf) m_ovf = 0;
            for (int b = 0; b < N; b++) begin
                mt_e = 2'b00;
                if (btn_db[b] && !m_prev[b]) begin
                    m_held[b] = 1; m_age[b] = 0; mt_e = 2'b01;
                end else if (!btn_db[b] && m_prev[b]) begin
                    if (m_held[b]) mt_e = 2'b11;
                    m_held[b] = 0;
                end else if (m_held[b] && mt_tick && repeat_en) begin
                    m_age[b]++;
                    if (m_age[b] >= HOLD && (m_age[b] - HOLD) % REP == 0) mt_e = 2'b10;
                end
                m_prev[b] = btn_db[b];
                if (mt_e != 2'b00) begin
                    if (!m_pend[b]) begin
                        m_pend[b] = 1; m_ptype[b] = mt_e;
                    end else if (mt_e == 2'b11 && m_ptype[b] == 2'b10) begin
                        m_ptype[b] = 2'b11;
                    end else if (mt_e != 2'b10) begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    // Transfers observed at the edge where they happen
    always @(posedge clk) begin
        if (rst && evif.ev_valid === 1'b1 && evif.ev_ready === 1'b1) begin
            if (evif.ev_type == 2'b01) n_press++;
            if (evif.ev_type == 2'b10) n_rpt++;
            if (evif.ev_type == 2'b11) n_rel++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        chk("ev_valid", 32'(evif.ev_valid), 32'(m_valid));
        if (m_valid) begin
            chk("ev_id", 32'(evif.ev_id), 32'(m_id));
            chk("ev_type", 32'(evif.ev_type), 32'(m_type));
        end
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_out();
        end
    endtask

    initial begin
        int  r0, e0, idx;
        bit  found;
        evif.ev_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(evif.ev_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b1;
        cyc(3);

        // 1: single press / release on button 2
        r0 = n_rpt;
        btn_db[2] = 1'b1;
        cyc(2);
        chk("s1_press_v", 32'(evif.ev_valid), 1);
        chk("s1_press_id", 32'(evif.ev_id), 2);
        chk("s1_press_t", 32'(evif.ev_type), 1);
        cyc(28);
        btn_db[2] = 1'b0;
        cyc(2);
        chk("s1_rel_v", 32'(evif.ev_valid), 1);
        chk("s1_rel_t", 32'(evif.ev_type), 3);
        cyc(10);
        chk("s1_no_rpt", 32'(n_rpt - r0), 0);

        // 2: 120-cycle hold gives four repeats
        r0 = n_rpt;
        btn_db[1] = 1'b1;
        cyc(120);
        btn_db[1] = 1'b0;
        cyc(10);
        chk("s2_rpt_cnt", 32'(n_rpt - r0), 4);

        // 3: simultaneous presses, pointer at 0 then at 1
        rst = 1'b0; cyc(1); rst = 1'b1; cyc(2);
        btn_db = 4'hF;
        cyc(1);
        for (int j = 0; j < N; j++) begin
            cyc(1);
            chk("s3_rr0_id", 32'(evif.ev_id), 32'(j));
        end
        cyc(5);
        btn_db = 4'h0; cyc(10);
        btn_db[0] = 1'b1; cyc(5);
        btn_db[0] = 1'b0; cyc(5);
        btn_db = 4'hF;
        cyc(1);
        for (int j = 0; j < N; j++) begin
            cyc(1);
            chk("s3_rr1_id", 32'(evif.ev_id), 32'((j + 1) % N));
        end
        cyc(5);
        btn_db = 4'h0; cyc(10);

        // 4: backpressure, overflow and its clear
        evif.ev_ready = 1'b0;
        btn_db[0] = 1'b1; cyc(8);
        btn_db[0] = 1'b0; cyc(8);
        btn_db[0] = 1'b1; cyc(8);
        btn_db[0] = 1'b0; cyc(26);
        chk("s4_hold_v", 32'(evif.ev_valid), 1);
        chk("s4_hold_id", 32'(evif.ev_id), 0);
        chk("s4_hold_t", 32'(evif.ev_type), 1);
        chk("s4_ovf", 32'(ovf), 1);
        evif.ev_ready = 1'b1;
        cyc(1);
        chk("s4_rel_t", 32'(evif.ev_type), 3);
        cyc(3);
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        chk("s4_ovf_clr", 32'(ovf), 0);
        cyc(5);

        // 5a: fall on the exact edge of the second repeat expiry
        r0 = n_rpt;
        found = 0;
        btn_db[0] = 1'b1;
        for (int t = 0; t < 200 && !found; t++) begin
            cyc(1);
            if (m_held[0] && (m_cyc % TD) == TD - 1 && m_age[0] + 1 == HOLD + REP) begin
                btn_db[0] = 1'b0;
                found = 1;
            end
        end
        chk("s5_found", 32'(found), 1);
        btn_db[0] = 1'b0;
        cyc(2);
        chk("s5_rel_t", 32'(evif.ev_type), 3);
        cyc(10);
        chk("s5_rpt_cnt", 32'(n_rpt - r0), 1);

        // 5b: repeats disabled over a long hold
        r0 = n_rpt;
        repeat_en = 1'b0;
        btn_db[3] = 1'b1; cyc(200);
        btn_db[3] = 1'b0; cyc(10);
        chk("s5_no_rpt", 32'(n_rpt - r0), 0);
        repeat_en = 1'b1;

        // 6: reset while an event is presented and a button is held
        evif.ev_ready = 1'b0;
        btn_db[1] = 1'b1; cyc(3);
        chk("s6_pre_v", 32'(evif.ev_valid), 1);
        rst = 1'b0; cyc(1); rst = 1'b1;
        chk("s6_v", 32'(evif.ev_valid), 0);
        chk("s6_ovf", 32'(ovf), 0);
        evif.ev_ready = 1'b1;
        e0 = n_press + n_rpt + n_rel;
        cyc(60);
        btn_db[1] = 1'b0; cyc(10);
        chk("s6_no_ev", 32'(n_press + n_rpt + n_rel - e0), 0);

        // Random traffic
        for (int t = 0; t < 4000; t++) begin
            cyc(1);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 39) == 0) btn_db[b] = ~btn_db[b];
            evif.ev_ready = ($urandom_range(0, 3) != 0);
            repeat_en     = ($urandom_range(0, 15) != 0);
            clr_ovf       = ($urandom_range(0, 31) == 0);
            rst           = ($urandom_range(0, 799) != 0);
            idx = t;
        end
        rst = 1'b1; clr_ovf = 1'b0; evif.ev_ready = 1'b1;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
